// File: rtl/clk_period_monitor_pkg.sv
// Shared types and constants for the mon_clk period monitor.
// Holds the FSM state encoding and the synchronizer depth.
package clk_period_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } fsm_state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/clk_period_monitor_sync_edge_det.sv
// Synchronizer plus rising-edge detector for an async level.
// Ports: clk, rst (sync, active-high), async_in, rise_pulse.
module sync_edge_det
    import clk_period_monitor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  edge_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], async_in};
            edge_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    // One clk cycle high per synchronized 0->1 transition.
    assign rise_pulse = sync_q[SYNC_DEPTH-1] & ~edge_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures mon_clk period in clk cycles; flags loss and overrun.
// Ports: clk, rst, mon_clk, period/period_val/period_rdy, lost, overrun.
module clk_period_monitor
    import clk_period_monitor_pkg::*;
#(
    parameter int p_cnt_width = 16,
    parameter int p_timeout   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mon_clk,
    output logic [p_cnt_width-1:0] period,
    output logic                   period_val,
    input  logic                   period_rdy,
    output logic                   lost,
    output logic                   overrun
);

    localparam logic [p_cnt_width-1:0] c_timeout =
        p_cnt_width'(p_timeout);
    localparam logic [p_cnt_width-1:0] c_one =
        p_cnt_width'(1);

    logic                   edge_pulse;
    fsm_state_t             state_q;
    fsm_state_t             state_d;
    logic [p_cnt_width-1:0] cnt_q;
    logic [p_cnt_width-1:0] cnt_d;
    logic                   capture;
    logic                   xfer;

    sync_edge_det u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (mon_clk),
        .rise_pulse (edge_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The timeout compare happens before the increment, so cnt
    // tops out at p_timeout and can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (edge_pulse) begin
                    state_d = MEASURE;
                    cnt_d   = c_one;
                end else if (cnt_q >= c_timeout) begin
                    state_d = LOST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            MEASURE: begin
                if (edge_pulse) begin
                    capture = 1'b1;
                    cnt_d   = c_one;
                end else if (cnt_q >= c_timeout) begin
                    state_d = LOST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            LOST: begin
                cnt_d = '0;
                if (edge_pulse) begin
                    state_d = MEASURE;
                    cnt_d   = c_one;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign xfer = period_val & period_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            period     <= '0;
            period_val <= 1'b0;
            overrun    <= 1'b0;
        end else if (capture) begin
            period     <= cnt_q;
            period_val <= 1'b1;
            // Only a capture landing on an unaccepted value is lost.
            if (period_val && !period_rdy) begin
                overrun <= 1'b1;
            end
        end else if (xfer) begin
            period_val <= 1'b0;
        end
    end

    assign lost = (state_q == LOST);

endmodule
